led_pattern_gen: RTL and testbench



---
 rtl/led_pattern_gen.sv | 157 +++++++++++++++
 tb/tb_led_pattern_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: run-time selectable LED pattern generator on the divided clock.
//
// Drives a WIDTH-bit LED bank with up/down count, rotate-left, bounce, Gray-up and
// hold patterns. A prescaler gates pattern steps to one per PRESCALE enabled cycles.
//
// Ports:
//   clk_divided  block clock (divided system clock)
//   rst          synchronous reset, active-high; overrides load and en
//   en           step enable; low freezes prescaler and pattern
//   mode         0 up, 1 down, 2 rotate-left, 3 bounce, 4 hold, 5 Gray-up, 6/7 hold
//   load         parallel load strobe; discards a coincident tick
//   load_value   value written to leds on load
//   leds         registered LED pattern
//   step_pulse   one-cycle pulse in the cycle leds shows a tick-updated value
//   wrap         one-cycle pulse on wrap or bounce turnaround; coincides with step_pulse

module led_pattern_gen #(
    parameter int unsigned       WIDTH    = 10,
    parameter int unsigned       PRESCALE = 1,
    parameter logic [WIDTH-1:0]  INIT     = '0
) (
    input  logic             clk_divided,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] leds,
    output logic             step_pulse,
    output logic             wrap
);

    localparam int unsigned      CntW    = 16;
    localparam logic [CntW-1:0]  CntLast = CntW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] One     = WIDTH'(1);
    localparam logic [WIDTH-1:0] AllOnes = '1;

    typedef enum logic {DirLeft, DirRight} dir_e;

    logic [WIDTH-1:0] leds_q, leds_d;
    logic [CntW-1:0]  count_q, count_d;
    dir_e             dir_q, dir_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;

    logic             tick;
    logic             one_hot;
    logic [WIDTH-1:0] gray_bin;
    logic [WIDTH-1:0] gray_bin_inc;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign tick         = en && (count_q == CntLast);
    // x & (x-1) clears the lowest set bit; zero result means at most one bit was set.
    assign one_hot      = (leds_q != '0) && ((leds_q & (leds_q - One)) == '0);
    assign gray_bin     = gray2bin(leds_q);
    assign gray_bin_inc = gray_bin + One;

    always_comb begin
        leds_d  = leds_q;
        count_d = count_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;

        if (load) begin
            leds_d  = load_value;
            count_d = '0;
            dir_d   = DirLeft;
        end else if (en) begin
            count_d = tick ? '0 : count_q + CntW'(1);
            if (tick) begin
                step_d = 1'b1;
                case (mode)
                    3'd0: begin
                        leds_d = leds_q + One;
                        wrap_d = (leds_q == AllOnes);
                    end
                    3'd1: begin
                        leds_d = leds_q - One;
                        wrap_d = (leds_q == '0);
                    end
                    3'd2: begin
                        if (!one_hot) begin
                            leds_d = One;
                            dir_d  = DirLeft;
                        end else begin
                            leds_d = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
                            wrap_d = leds_q[WIDTH-1];
                        end
                    end
                    3'd3: begin
                        if (!one_hot) begin
                            leds_d = One;
                            dir_d  = DirLeft;
                        end else if (dir_q == DirLeft) begin
                            if (leds_q[WIDTH-1]) begin
                                leds_d = leds_q >> 1;
                                dir_d  = DirRight;
                                wrap_d = 1'b1;
                            end else begin
                                leds_d = leds_q << 1;
                            end
                        end else begin
                            if (leds_q == One) begin
                                leds_d = leds_q << 1;
                                dir_d  = DirLeft;
                                wrap_d = 1'b1;
                            end else begin
                                leds_d = leds_q >> 1;
                            end
                        end
                    end
                    3'd5: begin
                        leds_d = bin2gray(gray_bin_inc);
                        wrap_d = (gray_bin == AllOnes);
                    end
                    default: begin
                        // Hold modes: pattern frozen, step still reported.
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_divided) begin
        if (rst) begin
            leds_q  <= INIT;
            count_q <= '0;
            dir_q   <= DirLeft;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            leds_q  <= leds_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    assign leds       = leds_q;
    assign step_pulse = step_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;

    localparam int unsigned W    = 10;
    localparam int unsigned Full = (1 << W) - 1;

    logic clk_divided = 1'b0;
    always #5 clk_divided = ~clk_divided;

    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic         load = 1'b0;
    logic [2:0]   mode = 3'd0;
    logic [W-1:0] load_value = '0;

    logic [W-1:0] leds1, leds3;
    logic         sp1, sp3, wr1, wr3;

    int tests = 0;
    int fails = 0;

    // Reference model state: index 0 -> PRESCALE=1 instance, index 1 -> PRESCALE=3.
    int unsigned m_leds [2];
    int unsigned m_cnt  [2];
    bit          m_right[2];
    bit          m_sp   [2];
    bit          m_wr   [2];
    int unsigned m_pre  [2] = '{1, 3};

    led_pattern_gen #(.WIDTH(W), .PRESCALE(1), .INIT('0)) dut1 (
        .clk_divided (clk_divided),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .load        (load),
        .load_value  (load_value),
        .leds        (leds1),
        .step_pulse  (sp1),
        .wrap        (wr1)
    );

    led_pattern_gen #(.WIDTH(W), .PRESCALE(3), .INIT('0)) dut3 (
        .clk_divided (clk_divided),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .load        (load),
        .load_value  (load_value),
        .leds        (leds3),
        .step_pulse  (sp3),
        .wrap        (wr3)
    );

    function automatic int popcount(int unsigned v);
        int n = 0;
        for (int i = 0; i < int'(W); i++) if (v[i]) n++;
        return n;
    endfunction

    function automatic int bit_pos(int unsigned v);
        for (int i = 0; i < int'(W); i++) if (v[i]) return i;
        return -1;
    endfunction

    // Gray decode: each binary bit is the parity of all Gray bits at or above it.
    function automatic int unsigned gray_to_int(int unsigned g);
        int unsigned b = 0;
        for (int i = 0; i < int'(W); i++) begin
            int p = 0;
            for (int j = i; j < int'(W); j++) p ^= int'(g[j]);
            if (p != 0) b += (1 << i);
        end
        return b;
    endfunction

    function automatic int unsigned int_to_gray(int unsigned b);
        return (b ^ (b / 2)) & Full;
    endfunction

    task automatic model_step(input int k);
        bit tick;
        int pos;
        int unsigned b;
        if (rst) begin
            m_leds[k] = 0; m_cnt[k] = 0; m_right[k] = 0; m_sp[k] = 0; m_wr[k] = 0;
        end else if (load) begin
            m_leds[k] = load_value; m_cnt[k] = 0; m_right[k] = 0; m_sp[k] = 0; m_wr[k] = 0;
        end else begin
            tick = en && (m_cnt[k] == m_pre[k] - 1);
            m_sp[k] = tick;
            m_wr[k] = 0;
            if (en) m_cnt[k] = tick ? 0 : m_cnt[k] + 1;
            if (tick) begin
                case (mode)
                    3'd0: begin
                        m_wr[k] = (m_leds[k] == Full);
                        m_leds[k] = (m_leds[k] + 1) % (Full + 1);
                    end
                    3'd1: begin
                        m_wr[k] = (m_leds[k] == 0);
                        m_leds[k] = (m_leds[k] + Full) % (Full + 1);
                    end
                    3'd2, 3'd3: begin
                        if (popcount(m_leds[k]) != 1) begin
                            m_leds[k] = 1; m_right[k] = 0;
                        end else if (mode == 3'd2) begin
                            pos = bit_pos(m_leds[k]);
                            m_wr[k] = (pos == int'(W) - 1);
                            m_leds[k] = 1 << ((pos + 1) % int'(W));
                        end else begin
                            pos = bit_pos(m_leds[k]);
                            if (!m_right[k]) begin
                                if (pos == int'(W) - 1) begin
                                    pos--; m_right[k] = 1; m_wr[k] = 1;
                                end else pos++;
                            end else begin
                                if (pos == 0) begin
                                    pos++; m_right[k] = 0; m_wr[k] = 1;
                                end else pos--;
                            end
                            m_leds[k] = 1 << pos;
                        end
                    end
                    3'd5: begin
                        b = gray_to_int(m_leds[k]);
                        m_wr[k] = (b == Full);
                        m_leds[k] = int_to_gray((b + 1) % (Full + 1));
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, step the model with the inputs present at the edge,
    // then compare both instances against the model.
    task automatic cyc();
        @(posedge clk_divided);
        model_step(0);
        model_step(1);
        #1;
        chk("p1_leds", 32'(leds1), m_leds[0]);
        chk("p1_step", 32'(sp1),   32'(m_sp[0]));
        chk("p1_wrap", 32'(wr1),   32'(m_wr[0]));
        chk("p3_leds", 32'(leds3), m_leds[1]);
        chk("p3_step", 32'(sp3),   32'(m_sp[1]));
        chk("p3_wrap", 32'(wr3),   32'(m_wr[1]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_load(input logic [W-1:0] v, input logic [2:0] m);
        load = 1'b1; load_value = v; mode = m;
        cyc();
        load = 1'b0;
    endtask

    int gray_seq[7] = '{1, 3, 2, 6, 7, 5, 4};
    int budget;

    initial begin
        // Reset and up count.
        rst = 1'b1; en = 1'b1; mode = 3'd0;
        run(2);
        chk("rst_leds", 32'(leds1), 32'h0);
        chk("rst_step", 32'(sp1), 32'h0);
        chk("rst_wrap", 32'(wr1), 32'h0);
        chk("rst_leds3", 32'(leds3), 32'h0);
        rst = 1'b0;
        cyc();
        chk("up_first", 32'(leds1), 32'h1);
        run(1023);
        chk("up_wrap_leds", 32'(leds1), 32'h0);
        chk("up_wrap_flag", 32'(wr1), 32'h1);
        cyc();
        chk("up_wrap_once", 32'(wr1), 32'h0);

        // Enable drop mid-count.
        run(4);
        en = 1'b0;
        run(5);
        en = 1'b1;
        run(7);

        // Load coincident with tick, then down-count wrap.
        do_load(10'h001, 3'd0);
        chk("load_leds", 32'(leds1), 32'h1);
        chk("load_step", 32'(sp1), 32'h0);
        mode = 3'd1;
        cyc();
        chk("down_zero", 32'(leds1), 32'h0);
        cyc();
        chk("down_wrap_leds", 32'(leds1), 32'h3FF);
        chk("down_wrap_flag", 32'(wr1), 32'h1);

        // Bounce.
        do_load(10'h001, 3'd3);
        run(9);
        chk("bounce_top", 32'(leds1), 32'h200);
        cyc();
        chk("bounce_turn", 32'(leds1), 32'h100);
        chk("bounce_turn_wrap", 32'(wr1), 32'h1);
        run(8);
        chk("bounce_bottom", 32'(leds1), 32'h001);
        cyc();
        chk("bounce_turn2", 32'(leds1), 32'h002);
        chk("bounce_turn2_wrap", 32'(wr1), 32'h1);
        do_load(10'h005, 3'd3);
        cyc();
        chk("bounce_recover", 32'(leds1), 32'h001);
        chk("bounce_recover_wrap", 32'(wr1), 32'h0);

        // Rotate and Gray.
        do_load(10'h200, 3'd2);
        cyc();
        chk("rot_leds", 32'(leds1), 32'h001);
        chk("rot_wrap", 32'(wr1), 32'h1);
        do_load(10'h000, 3'd5);
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("gray_seq", 32'(leds1), 32'(gray_seq[i]));
        end
        do_load(10'h200, 3'd5);
        cyc();
        chk("gray_wrap_leds", 32'(leds1), 32'h0);
        chk("gray_wrap_flag", 32'(wr1), 32'h1);

        // Reset mid-bounce with dir=RIGHT and prescaler count=1 on the PRESCALE=3 instance.
        do_load(10'h200, 3'd3);
        budget = 0;
        while (!(m_right[1] && m_cnt[1] == 1) && budget < 60) begin
            cyc();
            budget++;
        end
        chk("reach_right_cnt1", 32'(budget < 60), 32'h1);
        rst = 1'b1;
        cyc();
        chk("midrst_leds", 32'(leds3), 32'h0);
        chk("midrst_step", 32'(sp3), 32'h0);
        chk("midrst_wrap", 32'(wr3), 32'h0);
        rst = 1'b0;
        run(12);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(99) == 0);
            load       = ($urandom_range(19) == 0);
            en         = ($urandom_range(4) != 0);
            if ($urandom_range(7) == 0) mode = 3'($urandom_range(7));
            load_value = W'($urandom);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
